cipher_frame_packer: RTL and testbench

Downstream stage of message_encryptor. Collects ciphertext bytes over a valid/ready handshake and buffers one frame. It then emits that frame on a byte-wide valid/ready output as: SYNC, LEN, payload, CHK. This gives the receive side byte alignment and an integrity check before it feeds the matching decryptor.

---
 rtl/cipher_frame_packer.sv | 167 ++++++++++++++++
 tb/tb_cipher_frame_packer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_frame_packer.sv
// cipher_frame_packer: buffers one ciphertext frame, then re-emits it as
// SYNC, LEN, payload, CHK over a byte-wide valid/ready stream.
module cipher_frame_packer #(
   parameter int unsigned MAX_LEN   = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   input  logic        out_ready,
   output logic [15:0] frames_sent
);

   localparam int unsigned CW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      COLLECT = 3'd0,
      SYNC    = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [CW-1:0]   rd_idx;
   logic [CW-1:0]   rd_next;
   logic [7:0]      acc;
   logic [7:0]      acc_next;
   logic [15:0]     frames_next;
   logic            wr_en;
   logic            accept;
   logic            consume;
   logic            in_ready_next;
   logic            out_valid_next;
   logic            out_sof_next;
   logic            out_eof_next;
   logic [7:0]      out_data_next;
   logic [7:0]      frame_buf [MAX_LEN];

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, datapath updates and next values of the registered outputs
   always_comb begin
      state_next     = state;
      count_next     = count;
      rd_next        = rd_idx;
      acc_next       = acc;
      frames_next    = frames_sent;
      wr_en          = 1'b0;
      accept         = in_valid && in_ready;
      consume        = out_valid && out_ready;
      in_ready_next  = 1'b0;
      out_valid_next = 1'b0;
      out_sof_next   = 1'b0;
      out_eof_next   = 1'b0;
      out_data_next  = 8'h00;

      unique case (state)
         COLLECT: begin
            if (accept) begin
               wr_en      = 1'b1;
               count_next = count + CW'(1);
               acc_next   = acc ^ in_data;
               // A full buffer closes the frame even without in_last
               if (in_last || (count_next == CW'(MAX_LEN))) begin
                  state_next = SYNC;
               end
            end
         end
         SYNC: begin
            if (consume) begin
               rd_next    = '0;
               state_next = LEN;
            end
         end
         LEN: begin
            if (consume) begin
               state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (consume) begin
               rd_next = rd_idx + CW'(1);
               if (rd_idx == (count - CW'(1))) begin
                  state_next = CHK;
               end
            end
         end
         CHK: begin
            if (consume) begin
               frames_next = frames_sent + 16'd1;
               count_next  = '0;
               acc_next    = 8'h00;
               rd_next     = '0;
               state_next  = COLLECT;
            end
         end
         default: begin
            state_next = COLLECT;
         end
      endcase

      // Outputs are precomputed from the next state so they leave a register
      in_ready_next  = (state_next == COLLECT);
      out_valid_next = (state_next != COLLECT);
      out_sof_next   = (state_next == SYNC);
      out_eof_next   = (state_next == CHK);
      unique case (state_next)
         SYNC:    out_data_next = SYNC_BYTE;
         LEN:     out_data_next = 8'(count_next);
         PAYLOAD: out_data_next = frame_buf[AW'(rd_next)];
         CHK:     out_data_next = 8'(count_next) ^ acc_next;
         default: out_data_next = 8'h00;
      endcase
   end

   // Frame counters, checksum accumulator and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         count       <= '0;
         rd_idx      <= '0;
         acc         <= 8'h00;
         frames_sent <= 16'h0000;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_eof     <= 1'b0;
         out_data    <= 8'h00;
      end else begin
         count       <= count_next;
         rd_idx      <= rd_next;
         acc         <= acc_next;
         frames_sent <= frames_next;
         in_ready    <= in_ready_next;
         out_valid   <= out_valid_next;
         out_sof     <= out_sof_next;
         out_eof     <= out_eof_next;
         out_data    <= out_data_next;
      end
   end

   // Payload buffer write; contents are don't-care until the count covers them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         frame_buf[AW'(count)] <= in_data;
      end
   end

endmodule

// File: tb/tb_cipher_frame_packer.sv
// Testbench for cipher_frame_packer: cycle table for the basic and
// single-byte frames, directed corner sequences, random traffic against a
// frame-level scoreboard, and a 19-byte loopback on a wider instance.
module tb_cipher_frame_packer;

   localparam int unsigned MAX_LEN = 16;
   localparam int unsigned LB_LEN  = 24;
   localparam logic [7:0]  SYNC_B  = 8'hA5;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_eof;
   logic        out_ready;
   logic [15:0] frames_sent;

   logic [7:0]  l_in_data;
   logic        l_in_valid;
   logic        l_in_last;
   logic        l_in_ready;
   logic [7:0]  l_out_data;
   logic        l_out_valid;
   logic        l_out_sof;
   logic        l_out_eof;
   logic        l_out_ready;
   logic [15:0] l_frames_sent;

   always #5 clk = ~clk;

   cipher_frame_packer #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC_B)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
      .out_ready(out_ready), .frames_sent(frames_sent)
   );

   cipher_frame_packer #(.MAX_LEN(LB_LEN), .SYNC_BYTE(SYNC_B)) lb_dut (
      .clk(clk), .reset(reset),
      .in_data(l_in_data), .in_valid(l_in_valid), .in_last(l_in_last), .in_ready(l_in_ready),
      .out_data(l_out_data), .out_valid(l_out_valid), .out_sof(l_out_sof), .out_eof(l_out_eof),
      .out_ready(l_out_ready), .frames_sent(l_frames_sent)
   );

   typedef struct {
      logic [7:0] data;
      logic       sof;
      logic       eof;
   } obyte_t;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       il;
      logic       ordy;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_sof;
      logic       e_eof;
      logic       e_ir;
   } vec_t;

   obyte_t      exp_q[$];
   logic [7:0]  cur_q[$];
   logic [15:0] frames_exp = 16'd0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          live = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data;
   logic        prev_sof;
   logic        prev_eof;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference: a frame closes on in_last or when MAX_LEN bytes are held
   task automatic model_accept(input logic [7:0] b, input logic last);
      logic [7:0] x;
      logic [7:0] len;
      cur_q.push_back(b);
      if (last || (cur_q.size() == MAX_LEN)) begin
         x   = 8'h00;
         len = 8'(cur_q.size());
         exp_q.push_back('{data: SYNC_B, sof: 1'b1, eof: 1'b0});
         exp_q.push_back('{data: len, sof: 1'b0, eof: 1'b0});
         foreach (cur_q[i]) begin
            x ^= cur_q[i];
            exp_q.push_back('{data: cur_q[i], sof: 1'b0, eof: 1'b0});
         end
         exp_q.push_back('{data: len ^ x, sof: 1'b0, eof: 1'b1});
         cur_q.delete();
      end
   endtask

   // Called at the negedge: invariant checks, scoreboard update, then advance one edge
   task automatic observe();
      obyte_t e;
      if (live) begin
         chk("ready_vs_valid", 32'(in_ready ^ out_valid), 32'd1);
         chk("frames_sent", 32'(frames_sent), 32'(frames_exp));
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_sof", 32'(out_sof), 32'(prev_sof));
            chk("stall_eof", 32'(out_eof), 32'(prev_eof));
         end
      end
      if (!reset) begin
         cur_q.delete();
         exp_q.delete();
         frames_exp = 16'd0;
         prev_stall = 1'b0;
      end else if (live) begin
         if (in_valid && in_ready) model_accept(in_data, in_last);
         if (out_valid && out_ready) begin
            chk("out_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_sof", 32'(out_sof), 32'(e.sof));
               chk("out_eof", 32'(out_eof), 32'(e.eof));
               if (e.eof) frames_exp++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_sof   = out_sof;
         prev_eof   = out_eof;
      end
      @(posedge clk);
      if (!reset) live = 1'b1;
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      observe();
   endtask

   task automatic drive(input logic iv, input logic [7:0] id, input logic il, input logic ordy);
      in_valid  = iv;
      in_data   = id;
      in_last   = il;
      out_ready = ordy;
   endtask

   // Present one byte until accepted (bounded), then drop in_valid
   task automatic send(input logic [7:0] b, input logic last);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         observe();
      end
      chk("send_accept", 32'(got), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input int budget);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic il,
                               input logic ordy, input logic e_ov, input logic [7:0] e_od,
                               input logic e_sof, input logic e_eof, input logic e_ir);
      vec_t v;
      v = '{iv: iv, id: id, il: il, ordy: ordy, e_ov: e_ov, e_od: e_od,
            e_sof: e_sof, e_eof: e_eof, e_ir: e_ir};
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t       vt[$];
      logic [7:0] ct[19];
      logic [7:0] key;
      logic [7:0] got_q[$];
      logic [7:0] x;
      bit         done;
      int         i;
      int         budget;

      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      l_in_valid  = 1'b0;
      l_in_data   = 8'h00;
      l_in_last   = 1'b0;
      l_out_ready = 1'b0;

      // basic frame then single-byte frame, cycle by cycle
      vt.push_back(mk(1, 8'h11, 0, 1,  0, 8'h00, 0, 0, 1));
      vt.push_back(mk(1, 8'h22, 0, 1,  0, 8'h00, 0, 0, 1));
      vt.push_back(mk(1, 8'h33, 1, 1,  0, 8'h00, 0, 0, 1));
      vt.push_back(mk(0, 8'h00, 0, 1,  1, 8'hA5, 1, 0, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  1, 8'h03, 0, 0, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  1, 8'h11, 0, 0, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  1, 8'h22, 0, 0, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  1, 8'h33, 0, 0, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  1, 8'h03, 0, 1, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 1));
      vt.push_back(mk(1, 8'h5A, 1, 1,  0, 8'h00, 0, 0, 1));
      vt.push_back(mk(1, 8'h77, 1, 1,  1, 8'hA5, 1, 0, 0));
      vt.push_back(mk(1, 8'h77, 1, 1,  1, 8'h01, 0, 0, 0));
      vt.push_back(mk(1, 8'h77, 1, 1,  1, 8'h5A, 0, 0, 0));
      vt.push_back(mk(1, 8'h77, 1, 1,  1, 8'h5B, 0, 1, 0));
      vt.push_back(mk(0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 1));

      // reset low for two cycles
      repeat (2) step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sof", 32'(out_sof), 32'd0);
      chk("rst_out_eof", 32'(out_eof), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_frames", 32'(frames_sent), 32'd0);
      observe();

      foreach (vt[k]) begin
         drive(vt[k].iv, vt[k].id, vt[k].il, vt[k].ordy);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", k), 32'(out_valid), 32'(vt[k].e_ov));
         chk($sformatf("tbl%0d_ready", k), 32'(in_ready), 32'(vt[k].e_ir));
         if (vt[k].e_ov) begin
            chk($sformatf("tbl%0d_data", k), 32'(out_data), 32'(vt[k].e_od));
            chk($sformatf("tbl%0d_sof", k), 32'(out_sof), 32'(vt[k].e_sof));
            chk($sformatf("tbl%0d_eof", k), 32'(out_eof), 32'(vt[k].e_eof));
         end
         observe();
      end
      chk("tbl_frames", 32'(frames_sent), 32'd2);

      // auto-close at MAX_LEN without in_last
      for (int b = 0; b < 16; b++) begin
         drive(1'b1, 8'(b), 1'b0, 1'b1);
         step();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      chk("auto_sof", 32'(out_sof), 32'd1);
      chk("auto_in_ready", 32'(in_ready), 32'd0);
      observe();
      drain(100);
      chk("auto_frames", 32'(frames_sent), 32'd3);

      // backpressure with out_ready 1,0,0,1,0,0...
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
         out_ready = ((k % 3) == 0);
         step();
      end
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      chk("bp_frames", 32'(frames_sent), 32'd4);

      // reset after two of three input bytes
      out_ready = 1'b1;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("mrst1_valid", 32'(out_valid), 32'd0);
      chk("mrst1_ready", 32'(in_ready), 32'd1);
      chk("mrst1_frames", 32'(frames_sent), 32'd0);
      observe();
      send(8'h44, 1'b0);
      send(8'h55, 1'b0);
      send(8'h66, 1'b1);
      drain(50);
      chk("mrst1_next_frames", 32'(frames_sent), 32'd1);

      // reset during PAYLOAD
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      send(8'hA4, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (3) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("mrst2_valid", 32'(out_valid), 32'd0);
      chk("mrst2_ready", 32'(in_ready), 32'd1);
      chk("mrst2_frames", 32'(frames_sent), 32'd0);
      observe();
      send(8'hB1, 1'b0);
      send(8'hB2, 1'b1);
      drain(50);
      chk("mrst2_next_frames", 32'(frames_sent), 32'd1);

      // random traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         in_last   = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 399) != 0);
         step();
      end
      reset = 1'b1;
      drain(100);
      chk("rand_frames", 32'(frames_sent), 32'(frames_exp));

      // loopback: 19-byte toy ciphertext stream into the wider instance
      key = 8'h3C;
      for (int k = 0; k < 19; k++) begin
         key   = {key[6:0], key[7] ^ key[5] ^ key[4] ^ key[3]};
         ct[k] = 8'(k * 7 + 8'h41) ^ key;
      end
      i = 0;
      budget = 200;
      while (i < 19 && budget > 0) begin
         l_in_valid = 1'b1;
         l_in_data  = ct[i];
         l_in_last  = (i == 18);
         @(negedge clk);
         if (l_in_ready) i++;
         @(posedge clk);
         #1;
         budget--;
      end
      chk("lb_all_sent", 32'(i), 32'd19);
      l_in_valid  = 1'b0;
      l_in_last   = 1'b0;
      l_out_ready = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (l_out_valid) begin
            got_q.push_back(l_out_data);
            if (l_out_eof) done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      chk("lb_out_len", 32'(got_q.size()), 32'd22);
      if (got_q.size() == 22) begin
         chk("lb_sync", 32'(got_q[0]), 32'(SYNC_B));
         chk("lb_len", 32'(got_q[1]), 32'h13);
         x = 8'h00;
         for (int k = 0; k < 19; k++) begin
            x ^= ct[k];
            chk($sformatf("lb_pay%0d", k), 32'(got_q[k + 2]), 32'(ct[k]));
         end
         chk("lb_chk", 32'(got_q[21]), 32'(8'h13 ^ x));
      end
      chk("lb_frames", 32'(l_frames_sent), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
